// File: rtl/assoc_cache_core.sv
// rtl/assoc_cache_core.sv - N-way set-associative cache core with tree PLRU and miss FSM
module assoc_cache_core #(
  parameter int WAYS       = 2,
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [255:0] mem_wdata,
  input  logic [31:0]  mem_byte_enable,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS      = 1 << INDEX_BITS;
  localparam int TAG_BITS  = 27 - INDEX_BITS;
  localparam int LOG_WAYS  = (WAYS > 1) ? $clog2(WAYS) : 0;
  localparam int WAY_BITS  = (WAYS > 1) ? LOG_WAYS : 1;
  localparam int PLRU_BITS = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {CHECK, WRITEBACK, FETCH} state_e;
  typedef logic [WAY_BITS-1:0]  way_t;
  typedef logic [PLRU_BITS-1:0] plru_t;

  state_e state_q;
  way_t   victim_q;
  logic   pmem_read_q;
  logic   pmem_write_q;

  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [255:0]        data_q  [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  plru_t               plru_q  [SETS];

  // PLRU tree is heap-ordered: node n has children 2n+1 (lower half) and 2n+2.
  function automatic way_t plru_victim(input plru_t bits);
    logic [7:0] b8;
    logic [7:0] w8;
    logic [2:0] node;
    b8   = 8'(bits);
    w8   = '0;
    node = '0;
    for (int l = 0; l < LOG_WAYS; l++) begin
      w8   = {w8[6:0], b8[node]};
      node = {node[1:0], 1'b0} + 3'd1 + {2'b00, b8[node]};
    end
    return way_t'(w8);
  endfunction

  function automatic plru_t plru_touch(input plru_t bits, input way_t way);
    logic [7:0] b8;
    logic [2:0] wa;
    logic [2:0] node;
    logic       dir;
    b8   = 8'(bits);
    wa   = 3'(way) << (3 - LOG_WAYS);
    node = '0;
    for (int l = 0; l < LOG_WAYS; l++) begin
      dir      = wa[2];
      b8[node] = ~dir;
      node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
      wa       = {wa[1:0], 1'b0};
    end
    return plru_t'(b8);
  endfunction

  logic                  req;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit;
  logic                  has_free;
  logic                  victim_dirty;
  way_t                  hit_way;
  way_t                  free_way;
  way_t                  victim_way;
  logic [255:0]          hit_line;
  logic [255:0]          merged_line;
  logic                  unused_offset;

  assign req           = mem_read | mem_write;
  assign idx           = mem_address[INDEX_BITS+4:5];
  assign req_tag       = mem_address[31:INDEX_BITS+5];
  assign unused_offset = ^mem_address[4:0];

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    free_way = '0;
    has_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = way_t'(w);
      end
      if (!valid_q[idx][w]) begin
        free_way = way_t'(w);
        has_free = 1'b1;
      end
    end
  end

  assign hit          = |hit_vec;
  assign victim_way   = has_free ? free_way : plru_victim(plru_q[idx]);
  assign victim_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];
  assign hit_line     = data_q[idx][hit_way];

  always_comb begin
    merged_line = hit_line;
    for (int i = 0; i < 32; i++) begin
      if (mem_byte_enable[i]) merged_line[i*8 +: 8] = mem_wdata[i*8 +: 8];
    end
  end

  assign mem_rdata    = hit_line;
  assign mem_resp     = (state_q == CHECK) && req && hit;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_wdata   = data_q[idx][victim_q];
  assign pmem_address = (state_q == WRITEBACK) ? {tag_q[idx][victim_q], idx, 5'b0}
                                               : {mem_address[31:5], 5'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CHECK;
      victim_q     <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        CHECK: begin
          if (req && hit) begin
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            if (mem_write) begin
              data_q[idx][hit_way]  <= merged_line;
              dirty_q[idx][hit_way] <= 1'b1;
            end
          end else if (req) begin
            victim_q <= victim_way;
            if (victim_dirty) begin
              state_q      <= WRITEBACK;
              pmem_write_q <= 1'b1;
            end else begin
              state_q     <= FETCH;
              pmem_read_q <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty_q[idx][victim_q] <= 1'b0;
            pmem_write_q           <= 1'b0;
            pmem_read_q            <= 1'b1;
            state_q                <= FETCH;
          end
        end
        FETCH: begin
          // The request re-enters CHECK and hits, where a write merges its bytes.
          if (pmem_resp) begin
            data_q[idx][victim_q]  <= pmem_rdata;
            tag_q[idx][victim_q]   <= req_tag;
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            pmem_read_q            <= 1'b0;
            state_q                <= CHECK;
          end
        end
        default: state_q <= CHECK;
      endcase
    end
  end

  hit_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit_vec));
  pmem_excl_a:  assert property (@(posedge clk) disable iff (!rst_n) !(pmem_read_q && pmem_write_q));

endmodule

// File: tb/tb_assoc_cache_core.sv
// tb/tb_assoc_cache_core.sv - directed and randomized checks of assoc_cache_core
module tb_assoc_cache_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         mem_read_a       [3];
  logic         mem_write_a      [3];
  logic [31:0]  mem_address_a    [3];
  logic [255:0] mem_wdata_a      [3];
  logic [31:0]  mem_be_a         [3];
  logic [255:0] mem_rdata_a      [3];
  logic         mem_resp_a       [3];
  logic         pmem_read_a      [3];
  logic         pmem_write_a     [3];
  logic [31:0]  pmem_address_a   [3];
  logic [255:0] pmem_wdata_a     [3];
  logic [255:0] pmem_rdata_a     [3];
  logic         pmem_resp_a      [3];

  assoc_cache_core #(.WAYS(2), .INDEX_BITS(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read_a[0]), .mem_write(mem_write_a[0]), .mem_address(mem_address_a[0]),
    .mem_wdata(mem_wdata_a[0]), .mem_byte_enable(mem_be_a[0]), .mem_rdata(mem_rdata_a[0]),
    .mem_resp(mem_resp_a[0]), .pmem_read(pmem_read_a[0]), .pmem_write(pmem_write_a[0]),
    .pmem_address(pmem_address_a[0]), .pmem_wdata(pmem_wdata_a[0]),
    .pmem_rdata(pmem_rdata_a[0]), .pmem_resp(pmem_resp_a[0])
  );

  assoc_cache_core #(.WAYS(1), .INDEX_BITS(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read_a[1]), .mem_write(mem_write_a[1]), .mem_address(mem_address_a[1]),
    .mem_wdata(mem_wdata_a[1]), .mem_byte_enable(mem_be_a[1]), .mem_rdata(mem_rdata_a[1]),
    .mem_resp(mem_resp_a[1]), .pmem_read(pmem_read_a[1]), .pmem_write(pmem_write_a[1]),
    .pmem_address(pmem_address_a[1]), .pmem_wdata(pmem_wdata_a[1]),
    .pmem_rdata(pmem_rdata_a[1]), .pmem_resp(pmem_resp_a[1])
  );

  assoc_cache_core #(.WAYS(4), .INDEX_BITS(3)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read_a[2]), .mem_write(mem_write_a[2]), .mem_address(mem_address_a[2]),
    .mem_wdata(mem_wdata_a[2]), .mem_byte_enable(mem_be_a[2]), .mem_rdata(mem_rdata_a[2]),
    .mem_resp(mem_resp_a[2]), .pmem_read(pmem_read_a[2]), .pmem_write(pmem_write_a[2]),
    .pmem_address(pmem_address_a[2]), .pmem_wdata(pmem_wdata_a[2]),
    .pmem_rdata(pmem_rdata_a[2]), .pmem_resp(pmem_resp_a[2])
  );

  int checks = 0;
  int errors = 0;
  int both_hi = 0;
  int align_bad = 0;
  int fetch_addr_bad = 0;

  logic [255:0] pmem_m [longint];
  logic [255:0] ref_m  [longint];
  logic [31:0]  last_pw_addr;
  logic [255:0] last_pw_data;
  logic [31:0]  last_pr_addr;
  bit           first_op_write;

  function automatic longint key(input int d, input logic [31:0] a);
    return (longint'(d) << 32) | longint'({a[31:5], 5'b0});
  endfunction

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[31:5], 5'b0} ^ 32'(32'h9E37_79B9 * (i + 1));
    return l;
  endfunction

  function automatic logic [255:0] get_pmem(input int d, input logic [31:0] a);
    return pmem_m.exists(key(d, a)) ? pmem_m[key(d, a)] : init_line(a);
  endfunction

  function automatic logic [255:0] get_ref(input int d, input logic [31:0] a);
    return ref_m.exists(key(d, a)) ? ref_m[key(d, a)] : init_line(a);
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd,
                                         input logic [31:0] be);
    logic [255:0] r;
    r = old;
    for (int i = 0; i < 32; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (pmem_read_a[d] && pmem_write_a[d]) both_hi++;
      if ((pmem_read_a[d] || pmem_write_a[d]) && (pmem_address_a[d][4:0] != 5'd0)) align_bad++;
    end
  end

  // Issues one request, plays physical memory with dly wait cycles per access.
  task automatic do_req(input int d, input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                        input logic [31:0] be, input int dly, output logic [255:0] rd,
                        output int lat, output int npr, output int npw, output bit ok);
    int waited;
    bit seen_op;
    waited = 0;
    seen_op = 0;
    rd = '0; lat = -1; npr = 0; npw = 0; ok = 0;
    mem_read_a[d] = !wr; mem_write_a[d] = wr; mem_address_a[d] = addr;
    mem_wdata_a[d] = wd; mem_be_a[d] = be;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (mem_resp_a[d]) begin
        rd = mem_rdata_a[d]; lat = c; ok = 1;
      end else if (pmem_write_a[d] || pmem_read_a[d]) begin
        if (waited >= dly) begin
          waited = 0;
          pmem_resp_a[d] = 1'b1;
          if (pmem_write_a[d]) begin
            npw++;
            pmem_m[key(d, pmem_address_a[d])] = pmem_wdata_a[d];
            last_pw_addr = pmem_address_a[d];
            last_pw_data = pmem_wdata_a[d];
            if (!seen_op) first_op_write = 1;
          end else begin
            npr++;
            if (pmem_address_a[d] !== {addr[31:5], 5'b0}) fetch_addr_bad++;
            pmem_rdata_a[d] = get_pmem(d, pmem_address_a[d]);
            last_pr_addr = pmem_address_a[d];
            if (!seen_op) first_op_write = 0;
          end
          seen_op = 1;
        end else begin
          waited++;
        end
      end
      @(posedge clk); #1;
      pmem_resp_a[d] = 1'b0;
    end
    mem_read_a[d] = 1'b0;
    mem_write_a[d] = 1'b0;
  endtask

  task automatic run_random(input int d, input int n);
    logic [5:0]   ln;
    logic [31:0]  addr;
    logic [31:0]  be;
    logic [255:0] wd;
    logic [255:0] exp_old;
    logic [255:0] rd;
    bit           wr;
    bit           ok;
    int           lat, npr, npw;
    for (int k = 0; k < n; k++) begin
      ln   = 6'($urandom_range(0, 63));
      addr = {2'b00, ln[5:4], 19'b0, ln[3:0], 5'($urandom)};
      wr   = ($urandom_range(0, 99) < 40);
      be   = $urandom;
      for (int i = 0; i < 8; i++) wd[i*32 +: 32] = $urandom;
      exp_old = get_ref(d, addr);
      do_req(d, wr, addr, wd, be, int'($urandom_range(0, 3)), rd, lat, npr, npw, ok);
      chk($sformatf("rand%0d_done", d), 256'(ok), 256'(1));
      chk($sformatf("rand%0d_line_%h", d, addr), rd, exp_old);
      chk($sformatf("rand%0d_pmem_ops", d), 256'(npr <= 1 && npw <= npr), 256'(1));
      if (wr) ref_m[key(d, addr)] = merge(exp_old, wd, be);
    end
  endtask

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [31:0]  be;
    int           exp_lat;
    int           exp_npr;
    int           exp_npw;
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [255:0] d0, d1, wd_hi, rd;
    int           lat, npr, npw;
    bit           ok, seen;

    d0    = init_line(32'h0000_0040);
    d1    = {d0[255:32], 32'hDEAD_BEEF};
    wd_hi = {{7{32'hFFFF_FFFF}}, 32'hDEAD_BEEF};
    vecs[0] = '{0, 32'h0000_0040, '0,    32'h0,         2, 1, 0, d0};
    vecs[1] = '{0, 32'h0000_0240, '0,    32'h0,         2, 1, 0, init_line(32'h0000_0240)};
    vecs[2] = '{0, 32'h0000_0040, '0,    32'h0,         0, 0, 0, d0};
    vecs[3] = '{1, 32'h0000_0040, wd_hi, 32'h0000_000F, 0, 0, 0, d0};
    vecs[4] = '{0, 32'h0000_0040, '0,    32'h0,         0, 0, 0, d1};
    vecs[5] = '{0, 32'h0000_0440, '0,    32'h0,         2, 1, 0, init_line(32'h0000_0440)};

    for (int d = 0; d < 3; d++) begin
      mem_read_a[d] = 0; mem_write_a[d] = 0; mem_address_a[d] = '0;
      mem_wdata_a[d] = '0; mem_be_a[d] = '0; pmem_rdata_a[d] = '0; pmem_resp_a[d] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_mem_resp", 256'(mem_resp_a[0]), 256'(0));
    chk("reset_pmem_read", 256'(pmem_read_a[0]), 256'(0));
    chk("reset_pmem_write", 256'(pmem_write_a[0]), 256'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_req(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd, lat, npr, npw, ok);
      chk($sformatf("vec%0d_done", i), 256'(ok), 256'(1));
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_pmem_reads", i), 256'(npr), 256'(vecs[i].exp_npr));
      chk($sformatf("vec%0d_pmem_writes", i), 256'(npw), 256'(vecs[i].exp_npw));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Dirty way 0 (0x040) is the PLRU victim for 0x640.
    do_req(0, 0, 32'h0000_0640, '0, '0, 0, rd, lat, npr, npw, ok);
    chk("dirty_evict_latency", 256'(lat), 256'(3));
    chk("dirty_evict_npw", 256'(npw), 256'(1));
    chk("dirty_evict_npr", 256'(npr), 256'(1));
    chk("dirty_evict_wb_first", 256'(first_op_write), 256'(1));
    chk("dirty_evict_wb_addr", 256'(last_pw_addr), 256'(32'h0000_0040));
    chk("dirty_evict_wb_data", last_pw_data, d1);
    chk("dirty_evict_fetch_addr", 256'(last_pr_addr), 256'(32'h0000_0640));
    chk("dirty_evict_rdata", rd, init_line(32'h0000_0640));

    do_req(0, 0, 32'h0000_0040, '0, '0, 0, rd, lat, npr, npw, ok);
    chk("refetch_npw", 256'(npw), 256'(0));
    chk("refetch_rdata", rd, d1);

    // Make both ways dirty so the next miss must write back, then reset mid-writeback.
    do_req(0, 1, 32'h0000_0640, {8{32'h1111_2222}}, 32'hFFFF_FFFF, 0, rd, lat, npr, npw, ok);
    chk("setup_w640_latency", 256'(lat), 256'(0));
    do_req(0, 1, 32'h0000_0040, {8{32'h3333_4444}}, 32'hFFFF_FFFF, 0, rd, lat, npr, npw, ok);
    chk("setup_w040_latency", 256'(lat), 256'(0));
    mem_read_a[0] = 1'b1;
    mem_address_a[0] = 32'h0000_0840;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (pmem_write_a[0]) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("wb_entered", 256'(seen), 256'(1));
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midwb_reset_pmem_write", 256'(pmem_write_a[0]), 256'(0));
    chk("midwb_reset_pmem_read", 256'(pmem_read_a[0]), 256'(0));
    chk("midwb_reset_mem_resp", 256'(mem_resp_a[0]), 256'(0));
    mem_read_a[0] = 1'b0;
    @(posedge clk); #1;
    do_req(0, 0, 32'h0000_0040, '0, '0, 0, rd, lat, npr, npw, ok);
    chk("post_reset_miss_npr", 256'(npr), 256'(1));
    chk("post_reset_miss_npw", 256'(npw), 256'(0));
    chk("post_reset_miss_latency", 256'(lat), 256'(2));
    chk("post_reset_rdata", rd, d1);

    run_random(1, 300);
    run_random(2, 300);

    chk("pmem_read_write_overlap", 256'(both_hi), 256'(0));
    chk("pmem_address_alignment", 256'(align_bad), 256'(0));
    chk("fetch_address", 256'(fetch_addr_bad), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_cache_core.md
Name: assoc_cache_core

Overview:
- Parametrised N-way set-associative cache core: tag/valid/dirty/data arrays, tree pseudo-LRU replacement and the miss-handling FSM in one block.
- Sits between the CPU-side 256-bit line interface (after the bus adapter) and physical memory.
- Successor to the direct-mapped cache datapath. Adds associativity, configurable set count, replacement policy, and integrated write-back/fetch sequencing.

Parameters:
WAYS, 2, number of ways; legal values 1, 2, 4, 8; 1 = direct-mapped, no PLRU state
INDEX_BITS, 4, set index width; SETS = 2^INDEX_BITS; TAG_BITS = 27 - INDEX_BITS

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset: one clock; reset is synchronous and active-low
mem_read  in  1  CPU line read request; held until mem_resp
mem_write  in  1  CPU line write request; held until mem_resp
mem_address  in  32  CPU address; [4:0] offset (ignored), [INDEX_BITS+4:5] index, [31:INDEX_BITS+5] tag
mem_wdata  in  256  CPU write line
mem_byte_enable  in  32  per-byte write mask for mem_wdata
mem_rdata  out  256  selected line on hit
mem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  memory fill request
pmem_write  out  1  memory write-back request
pmem_address  out  32  line-aligned memory address, [4:0]=0
pmem_wdata  out  256  victim line for write-back
pmem_rdata  in  256  fill data, valid with pmem_resp
pmem_resp  in  1  memory completion

Behaviour:
- Arrays: per set and way, a tag, valid bit, dirty bit and 256-bit line; per set, WAYS-1 PLRU bits. All are flop arrays with combinational read and write at the clock edge.
- Reset (rst_n=0 at an edge):
  - all valid, dirty and PLRU bits cleared; FSM to CHECK
  - mem_resp, pmem_read, pmem_write = 0 from the following cycle
  - data/tag contents don't-care
  - reset mid-miss abandons the transaction with no array update
- Request: req = mem_read | mem_write. Both asserted is illegal; treated as a write.
- Hit: any way with valid=1 and tag match. At most one way matches; multiple matches are a design error, flagged by an assertion.
- FSM CHECK:
  - idle with no req: mem_resp=0, no array writes
  - req and hit: mem_resp=1 combinationally in the same cycle, and mem_rdata = hit way line.
    - Write hit: bytes with mem_byte_enable[i]=1 replace byte i at the edge; dirty set to 1.
    - The PLRU of the set is updated at the edge to point away from the hit way.
  - req and miss: victim chosen = lowest-numbered invalid way, else the PLRU-indicated way. The victim way number is registered.
    - Next state is WRITEBACK if the victim is valid and dirty, else FETCH. mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_address = {victim tag, index, 5'b0}, pmem_wdata = victim line
  - on pmem_resp go to FETCH; the victim dirty bit is cleared at that edge
- FETCH:
  - pmem_read=1, pmem_address = {mem_address[31:5], 5'b0}
  - on pmem_resp, at that edge: victim line = pmem_rdata, tag = request tag, valid=1, dirty=0; go to CHECK
  - the request then hits on the next cycle; write-allocate merges the write there
- Latency:
  - hit = 0 extra cycles (resp in the first cycle of the request)
  - clean miss = fetch cycles + 1
  - dirty miss = write-back cycles + fetch cycles + 1
  - pmem_read and pmem_write are never both high
- PLRU (tree, WAYS>1):
  - bit=0 means the victim lies in the left (lower) half
  - on access, bits along the path are set to point away from the accessed way
  - WAYS=2: a single bit; victim = way 0 when it is 0
- Request inputs must stay stable from assertion to mem_resp; a change mid-miss is unsupported. A request dropped before mem_resp after a fill leaves the filled line valid.
- Set index wrap: the index is taken purely from address bits; no aliasing across sets.

Test Plan:
- Reset, then mem_read 0x0000_0040 -> pmem_read with pmem_address 0x0000_0040; pmem_resp with data D0 -> next cycle mem_resp=1, mem_rdata=D0, no pmem_write ever.
- Read 0x0000_0240 (same set 2, tag 1) after the case above -> fills way 1; re-read 0x0000_0040 -> hit, 0 extra cycles, no pmem activity.
- Write 0x0000_0040 with byte_enable 0x0000_000F, wdata bytes 0-3 = 0xDEADBEEF -> hit, mem_resp same cycle; later read returns D0 with bytes 0-3 replaced.
- With both ways full and the PLRU pointing at way 1 (last access 0x040), read 0x0000_0440 -> way 1 (clean) evicted, only pmem_read issued. Then read 0x0000_0640 -> dirty way 0 evicted: pmem_write to 0x0000_0040 carrying the modified line precedes pmem_read 0x0000_0640.
- Assert rst_n=0 during WRITEBACK -> next cycle pmem_write=0, mem_resp=0; a subsequent read of 0x0000_0040 misses.
- Regression: WAYS=1, INDEX_BITS=4 and WAYS=4, INDEX_BITS=3 random read/write traffic vs a reference memory model -> zero data mismatches, and pmem_read and pmem_write never both high.
